// File: rtl/axi_burst_split_pkg.sv
// Shared encodings for the AXI4 burst splitter: burst types, response codes,
// FSM states and the WRAP-length legality helper.
package axi_split_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ADDR,
      R_WAIT,
      R_RESP
   } rd_state_e;

   typedef enum logic [2:0] {
      W_IDLE,
      W_DATA,
      W_ISSUE,
      W_WAITB,
      W_RESP
   } wr_state_e;

   // Legal WRAP lengths (len field = beats - 1)
   localparam logic [7:0] WRAP_LEN_2  = 8'd1;
   localparam logic [7:0] WRAP_LEN_4  = 8'd3;
   localparam logic [7:0] WRAP_LEN_8  = 8'd7;
   localparam logic [7:0] WRAP_LEN_16 = 8'd15;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == WRAP_LEN_2) || (len == WRAP_LEN_4) ||
             (len == WRAP_LEN_8) || (len == WRAP_LEN_16);
   endfunction

   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_burst_split_if.sv
// AXI4 bus bundle (64-bit data, 32-bit address) used on both sides of the splitter.
interface axi_burst_split_if #(parameter int TAGW = 1);
   logic            arvalid, arready;
   logic [31:0]     araddr;
   logic [TAGW-1:0] arid;
   logic [7:0]      arlen;
   logic [1:0]      arburst;
   logic [2:0]      arsize;

   logic            rvalid, rready;
   logic [63:0]     rdata;
   logic [1:0]      rresp;
   logic [TAGW-1:0] rid;
   logic            rlast;

   logic            awvalid, awready;
   logic [31:0]     awaddr;
   logic [TAGW-1:0] awid;
   logic [7:0]      awlen;
   logic [1:0]      awburst;
   logic [2:0]      awsize;

   logic            wvalid, wready;
   logic [63:0]     wdata;
   logic [7:0]      wstrb;
   logic            wlast;

   logic            bvalid, bready;
   logic [1:0]      bresp;
   logic [TAGW-1:0] bid;

   modport master (
      output arvalid, araddr, arid, arlen, arburst, arsize, input arready,
      input  rvalid, rdata, rresp, rid, rlast, output rready,
      output awvalid, awaddr, awid, awlen, awburst, awsize, input awready,
      output wvalid, wdata, wstrb, wlast, input wready,
      input  bvalid, bresp, bid, output bready
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arburst, arsize, output arready,
      output rvalid, rdata, rresp, rid, rlast, input rready,
      input  awvalid, awaddr, awid, awlen, awburst, awsize, output awready,
      input  wvalid, wdata, wstrb, wlast, output wready,
      output bvalid, bresp, bid, input bready
   );
endinterface

// File: rtl/axi_burst_split_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
module axi_addr_gen
   import axi_split_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [2:0]  size,
   input  logic [7:0]  len,
   input  burst_e      burst,
   output logic [31:0] next_addr
);
   logic [31:0] step;
   logic [31:0] incr;
   logic [31:0] region_mask;

   always_comb begin
      step        = 32'd1 << size;
      incr        = addr + step;
      region_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
      next_addr   = incr;
      case (burst)
         BURST_FIXED: next_addr = addr;
         // Illegal WRAP lengths fall through to plain INCR
         BURST_WRAP: if (wrap_len_ok(len))
            next_addr = (addr & ~region_mask) | (incr & region_mask);
         default: next_addr = incr;
      endcase
   end
endmodule

// File: rtl/axi_burst_split.sv
// Splits AXI4 bursts into single-beat downstream transactions; reassembles
// R beats with rlast and merges write beats into one B response.
module axi_burst_split
   import axi_split_pkg::*;
#(
   parameter int TAGW = 1
) (
   input logic               aclk,
   input logic               rst,
   axi_burst_split_if.slave  s,
   axi_burst_split_if.master m
);
   rd_state_e       rstate;
   logic [31:0]     raddr, rnext;
   logic [TAGW-1:0] rid_q;
   logic [7:0]      rlen, rcnt;
   burst_e          rburst;
   logic [2:0]      rsize;

   wr_state_e       wstate;
   logic [31:0]     waddr, wnext;
   logic [TAGW-1:0] wid_q;
   logic [7:0]      wlen, wcnt;
   burst_e          wburst;
   logic [2:0]      wsize;
   logic            werr;
   logic [1:0]      bacc, bmerged;

   axi_addr_gen u_rd_addr (.addr(raddr), .size(rsize), .len(rlen), .burst(rburst), .next_addr(rnext));
   axi_addr_gen u_wr_addr (.addr(waddr), .size(wsize), .len(wlen), .burst(wburst), .next_addr(wnext));

   assign m.araddr  = raddr;
   assign m.arid    = rid_q;
   assign m.arlen   = '0;
   assign m.arburst = BURST_INCR;
   assign m.arsize  = rsize;
   assign m.rready  = 1'b1;
   assign s.rid     = rid_q;

   assign m.awaddr  = waddr;
   assign m.awid    = wid_q;
   assign m.awlen   = '0;
   assign m.awburst = BURST_INCR;
   assign m.awsize  = wsize;
   assign m.wlast   = 1'b1;
   assign m.bready  = 1'b1;
   assign s.bid     = wid_q;

   always_comb bmerged = resp_max(bacc, m.bresp);

   always_ff @(posedge aclk) begin
      if (rst) begin
         rstate    <= R_IDLE;
         s.arready <= 1'b1;
         m.arvalid <= 1'b0;
         s.rvalid  <= 1'b0;
         s.rlast   <= 1'b0;
         s.rdata   <= '0;
         s.rresp   <= '0;
         raddr     <= '0;
         rid_q     <= '0;
         rlen      <= '0;
         rcnt      <= '0;
         rburst    <= BURST_INCR;
         rsize     <= '0;
      end else begin
         case (rstate)
            R_IDLE: if (s.arvalid) begin
               raddr     <= s.araddr;
               rid_q     <= s.arid;
               rlen      <= s.arlen;
               rburst    <= burst_e'(s.arburst);
               rsize     <= s.arsize;
               rcnt      <= '0;
               s.arready <= 1'b0;
               m.arvalid <= 1'b1;
               rstate    <= R_ADDR;
            end
            R_ADDR: if (m.arready) begin
               m.arvalid <= 1'b0;
               rstate    <= R_WAIT;
            end
            R_WAIT: if (m.rvalid) begin
               s.rdata  <= m.rdata;
               s.rresp  <= m.rresp;
               s.rlast  <= (rcnt == rlen);
               s.rvalid <= 1'b1;
               rstate   <= R_RESP;
            end
            R_RESP: if (s.rready) begin
               s.rvalid <= 1'b0;
               s.rlast  <= 1'b0;
               if (rcnt == rlen) begin
                  s.arready <= 1'b1;
                  rstate    <= R_IDLE;
               end else begin
                  raddr     <= rnext;
                  rcnt      <= rcnt + 8'd1;
                  m.arvalid <= 1'b1;
                  rstate    <= R_ADDR;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         wstate    <= W_IDLE;
         s.awready <= 1'b1;
         s.wready  <= 1'b0;
         s.bvalid  <= 1'b0;
         s.bresp   <= '0;
         m.awvalid <= 1'b0;
         m.wvalid  <= 1'b0;
         m.wdata   <= '0;
         m.wstrb   <= '0;
         waddr     <= '0;
         wid_q     <= '0;
         wlen      <= '0;
         wcnt      <= '0;
         wburst    <= BURST_INCR;
         wsize     <= '0;
         werr      <= 1'b0;
         bacc      <= RESP_OKAY;
      end else begin
         case (wstate)
            W_IDLE: if (s.awvalid) begin
               waddr     <= s.awaddr;
               wid_q     <= s.awid;
               wlen      <= s.awlen;
               wburst    <= burst_e'(s.awburst);
               wsize     <= s.awsize;
               wcnt      <= '0;
               werr      <= 1'b0;
               bacc      <= RESP_OKAY;
               s.awready <= 1'b0;
               s.wready  <= 1'b1;
               wstate    <= W_DATA;
            end
            // wlast is only checked; the beat count alone ends the burst
            W_DATA: if (s.wvalid) begin
               m.wdata   <= s.wdata;
               m.wstrb   <= s.wstrb;
               if (s.wlast != (wcnt == wlen)) werr <= 1'b1;
               s.wready  <= 1'b0;
               m.awvalid <= 1'b1;
               m.wvalid  <= 1'b1;
               wstate    <= W_ISSUE;
            end
            W_ISSUE: if (m.awready && m.wready) begin
               m.awvalid <= 1'b0;
               m.wvalid  <= 1'b0;
               wstate    <= W_WAITB;
            end
            W_WAITB: if (m.bvalid) begin
               bacc <= bmerged;
               if (wcnt == wlen) begin
                  s.bresp  <= werr ? resp_max(bmerged, RESP_SLVERR) : bmerged;
                  s.bvalid <= 1'b1;
                  wstate   <= W_RESP;
               end else begin
                  waddr    <= wnext;
                  wcnt     <= wcnt + 8'd1;
                  s.wready <= 1'b1;
                  wstate   <= W_DATA;
               end
            end
            W_RESP: if (s.bready) begin
               s.bvalid  <= 1'b0;
               s.awready <= 1'b1;
               wstate    <= W_IDLE;
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_burst_split.sv
// Scoreboard bench for axi_burst_split against a single-beat memory model.
module tb_axi_burst_split;
   import axi_split_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_burst_split_if #(.TAGW(1)) s_bus ();
   axi_burst_split_if #(.TAGW(1)) m_bus ();

   axi_burst_split #(.TAGW(1)) dut (.aclk(clk), .rst(rst), .s(s_bus), .m(m_bus));

   int errors = 0;
   int checks = 0;
   int r_popped = 0;

   typedef struct { logic [31:0] addr; logic [0:0] id; } ar_exp_t;
   typedef struct { logic [63:0] data; logic [1:0] resp; logic [0:0] id; logic last; } r_exp_t;
   typedef struct { logic [31:0] addr; logic [63:0] data; logic [7:0] strb; } w_exp_t;
   typedef struct { logic [1:0] resp; logic [0:0] id; } b_exp_t;

   ar_exp_t ar_q[$];
   r_exp_t  r_q[$];
   w_exp_t  w_q[$];
   b_exp_t  b_q[$];

   logic [63:0] mem [logic [28:0]];

   function automatic logic [63:0] defpat(input logic [31:0] a);
      return {32'hC0DE_0000, a & ~32'h7};
   endfunction

   function automatic logic [63:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a[31:3])) return mem[a[31:3]];
      return defpat(a);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: got %s", name, what);
   endtask

   task automatic exp_rd(input logic [31:0] a, input logic [0:0] id, input logic [63:0] d, input logic l);
      ar_q.push_back('{addr: a, id: id});
      r_q.push_back('{data: d, resp: RESP_OKAY, id: id, last: l});
   endtask

   // Downstream single-beat memory: always ready, responds one cycle after handshake
   initial begin
      logic        ar_hs, w_hs;
      logic [31:0] ar_a, w_a;
      logic [0:0]  ar_id, aw_id;
      logic [63:0] w_d, cur;
      logic [7:0]  w_s;
      m_bus.arready = 1'b1; m_bus.awready = 1'b1; m_bus.wready = 1'b1;
      m_bus.rvalid = 1'b0;  m_bus.rdata = '0; m_bus.rresp = '0; m_bus.rid = '0; m_bus.rlast = 1'b0;
      m_bus.bvalid = 1'b0;  m_bus.bresp = '0; m_bus.bid = '0;
      forever begin
         @(negedge clk);
         ar_hs = (m_bus.arvalid === 1'b1);
         ar_a  = m_bus.araddr;
         ar_id = m_bus.arid;
         w_hs  = (m_bus.awvalid === 1'b1) && (m_bus.wvalid === 1'b1);
         w_a   = m_bus.awaddr;
         aw_id = m_bus.awid;
         w_d   = m_bus.wdata;
         w_s   = m_bus.wstrb;
         @(posedge clk);
         #1;
         m_bus.rvalid = ar_hs;
         if (ar_hs) begin
            m_bus.rdata = mem_rd(ar_a);
            m_bus.rid   = ar_id;
            m_bus.rlast = 1'b1;
         end
         m_bus.bvalid = w_hs;
         if (w_hs) begin
            cur = mem_rd(w_a);
            for (int i = 0; i < 8; i++)
               if (w_s[i]) cur[8*i +: 8] = w_d[8*i +: 8];
            mem[w_a[31:3]] = cur;
            m_bus.bid = aw_id;
         end
      end
   end

   // Monitors: pop expectations whenever a handshake is presented
   initial begin
      ar_exp_t e;
      forever begin
         @(negedge clk);
         if (m_bus.arvalid === 1'b1 && m_bus.arready) begin
            if (ar_q.size() == 0) fail("m_ar_unexpected", $sformatf("araddr %h, expected none", m_bus.araddr));
            else begin
               e = ar_q.pop_front();
               chk("m_araddr", m_bus.araddr, e.addr);
               chk("m_arid", m_bus.arid, e.id);
               chk("m_arlen", m_bus.arlen, 8'd0);
               chk("m_arburst", m_bus.arburst, 2'b01);
            end
         end
      end
   end

   initial begin
      w_exp_t e;
      forever begin
         @(negedge clk);
         if (m_bus.awvalid === 1'b1 && m_bus.wvalid === 1'b1) begin
            if (w_q.size() == 0) fail("m_w_unexpected", $sformatf("awaddr %h, expected none", m_bus.awaddr));
            else begin
               e = w_q.pop_front();
               chk("m_awaddr", m_bus.awaddr, e.addr);
               chk("m_wdata", m_bus.wdata, e.data);
               chk("m_wstrb", m_bus.wstrb, e.strb);
               chk("m_awlen", m_bus.awlen, 8'd0);
               chk("m_awburst", m_bus.awburst, 2'b01);
            end
         end
      end
   end

   initial begin
      r_exp_t e;
      forever begin
         @(negedge clk);
         if (s_bus.rvalid === 1'b1 && s_bus.rready) begin
            if (r_q.size() == 0) fail("s_r_unexpected", $sformatf("rdata %h, expected none", s_bus.rdata));
            else begin
               e = r_q.pop_front();
               chk("s_rdata", s_bus.rdata, e.data);
               chk("s_rresp", s_bus.rresp, e.resp);
               chk("s_rid", s_bus.rid, e.id);
               chk("s_rlast", s_bus.rlast, e.last);
               r_popped++;
            end
         end
      end
   end

   initial begin
      b_exp_t e;
      forever begin
         @(negedge clk);
         if (s_bus.bvalid === 1'b1 && s_bus.bready) begin
            if (b_q.size() == 0) fail("s_b_unexpected", $sformatf("bresp %h, expected none", s_bus.bresp));
            else begin
               e = b_q.pop_front();
               chk("s_bresp", s_bus.bresp, e.resp);
               chk("s_bid", s_bus.bid, e.id);
            end
         end
      end
   end

   task automatic do_ar(input logic [31:0] a, input logic [0:0] id, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size);
      int n = 0;
      s_bus.araddr = a; s_bus.arid = id; s_bus.arlen = len; s_bus.arburst = burst; s_bus.arsize = size;
      s_bus.arvalid = 1'b1;
      do begin @(negedge clk); n++; end while (s_bus.arready !== 1'b1 && n < 200);
      if (s_bus.arready !== 1'b1) fail("ar_handshake", "timeout, expected arready");
      @(posedge clk); #1;
      s_bus.arvalid = 1'b0;
   endtask

   task automatic do_aw(input logic [31:0] a, input logic [0:0] id, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size);
      int n = 0;
      s_bus.awaddr = a; s_bus.awid = id; s_bus.awlen = len; s_bus.awburst = burst; s_bus.awsize = size;
      s_bus.awvalid = 1'b1;
      do begin @(negedge clk); n++; end while (s_bus.awready !== 1'b1 && n < 200);
      if (s_bus.awready !== 1'b1) fail("aw_handshake", "timeout, expected awready");
      @(posedge clk); #1;
      s_bus.awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
      int n = 0;
      s_bus.wdata = d; s_bus.wstrb = strb; s_bus.wlast = last;
      s_bus.wvalid = 1'b1;
      do begin @(negedge clk); n++; end while (s_bus.wready !== 1'b1 && n < 200);
      if (s_bus.wready !== 1'b1) fail("w_handshake", "timeout, expected wready");
      @(posedge clk); #1;
      s_bus.wvalid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((ar_q.size() + r_q.size() + w_q.size() + b_q.size()) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if ((ar_q.size() + r_q.size() + w_q.size() + b_q.size()) != 0)
         fail(tag, $sformatf("ar=%0d r=%0d w=%0d b=%0d pending, expected none",
                             ar_q.size(), r_q.size(), w_q.size(), b_q.size()));
      @(posedge clk); #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_s_arready"}, s_bus.arready, 1'b1);
      chk({tag, "_s_awready"}, s_bus.awready, 1'b1);
      chk({tag, "_s_wready"},  s_bus.wready,  1'b0);
      chk({tag, "_s_rvalid"},  s_bus.rvalid,  1'b0);
      chk({tag, "_s_bvalid"},  s_bus.bvalid,  1'b0);
      chk({tag, "_m_arvalid"}, m_bus.arvalid, 1'b0);
      chk({tag, "_m_awvalid"}, m_bus.awvalid, 1'b0);
      chk({tag, "_m_wvalid"},  m_bus.wvalid,  1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] t_incr[4];
      logic [31:0] t_wrap[4];
      int lat;
      int n;
      int r_base;
      t_incr = '{32'h8000_0010, 32'h8000_0018, 32'h8000_0020, 32'h8000_0028};
      t_wrap = '{32'h8000_0008, 32'h8000_000C, 32'h8000_0000, 32'h8000_0004};

      s_bus.arvalid = 1'b0; s_bus.araddr = '0; s_bus.arid = '0; s_bus.arlen = '0;
      s_bus.arburst = '0;   s_bus.arsize = '0; s_bus.rready = 1'b1;
      s_bus.awvalid = 1'b0; s_bus.awaddr = '0; s_bus.awid = '0; s_bus.awlen = '0;
      s_bus.awburst = '0;   s_bus.awsize = '0;
      s_bus.wvalid = 1'b0;  s_bus.wdata = '0;  s_bus.wstrb = '0; s_bus.wlast = 1'b0;
      s_bus.bready = 1'b1;

      @(negedge clk);
      check_idle("reset");
      chk("reset_s_rdata", s_bus.rdata, 64'd0);
      chk("reset_s_rlast", s_bus.rlast, 1'b0);
      chk("reset_s_bresp", s_bus.bresp, 2'b00);
      chk("reset_s_rid",   s_bus.rid,   1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // INCR read, 4 beats of 8 bytes
      for (int i = 0; i < 4; i++) exp_rd(t_incr[i], 1'b1, defpat(t_incr[i]), i == 3);
      do_ar(32'h8000_0010, 1'b1, 8'd3, 2'b01, 3'd3);
      lat = 0;
      do begin @(negedge clk); lat++; end while (s_bus.rvalid !== 1'b1 && lat < 20);
      chk("read_latency", lat, 3);
      wait_drain("incr_read_drain");

      // WRAP read, 4 beats of 4 bytes wrapping in a 16-byte region
      for (int i = 0; i < 4; i++) exp_rd(t_wrap[i], 1'b0, defpat(t_wrap[i]), i == 3);
      do_ar(32'h8000_0008, 1'b0, 8'd3, 2'b10, 3'd2);
      wait_drain("wrap_read_drain");

      // FIXED write, three beats to the same address, then read back
      w_q.push_back('{addr: 32'h8000_0100, data: 64'd1, strb: 8'hFF});
      w_q.push_back('{addr: 32'h8000_0100, data: 64'd2, strb: 8'hFF});
      w_q.push_back('{addr: 32'h8000_0100, data: 64'd3, strb: 8'hFF});
      b_q.push_back('{resp: RESP_OKAY, id: 1'b1});
      do_aw(32'h8000_0100, 1'b1, 8'd2, 2'b00, 3'd3);
      do_w(64'd1, 8'hFF, 1'b0);
      do_w(64'd2, 8'hFF, 1'b0);
      do_w(64'd3, 8'hFF, 1'b1);
      wait_drain("fixed_write_drain");
      exp_rd(32'h8000_0100, 1'b0, 64'd3, 1'b1);
      do_ar(32'h8000_0100, 1'b0, 8'd0, 2'b01, 3'd3);
      wait_drain("fixed_readback_drain");

      // Early wlast on beat 1: all three beats still go out, response is SLVERR
      w_q.push_back('{addr: 32'h8000_0400, data: 64'h11, strb: 8'hFF});
      w_q.push_back('{addr: 32'h8000_0408, data: 64'h22, strb: 8'h0F});
      w_q.push_back('{addr: 32'h8000_0410, data: 64'h33, strb: 8'hF0});
      b_q.push_back('{resp: RESP_SLVERR, id: 1'b0});
      do_aw(32'h8000_0400, 1'b0, 8'd2, 2'b01, 3'd3);
      do_w(64'h11, 8'hFF, 1'b0);
      do_w(64'h22, 8'h0F, 1'b1);
      do_w(64'h33, 8'hF0, 1'b0);
      wait_drain("wlast_err_drain");
      exp_rd(32'h8000_0408, 1'b1, 64'hC0DE_0000_0000_0022, 1'b1);
      do_ar(32'h8000_0408, 1'b1, 8'd0, 2'b01, 3'd3);
      wait_drain("strb_readback_drain");

      // Upstream R backpressure on beat 0
      s_bus.rready = 1'b0;
      exp_rd(32'h8000_0200, 1'b1, defpat(32'h8000_0200), 1'b0);
      exp_rd(32'h8000_0208, 1'b1, defpat(32'h8000_0208), 1'b1);
      do_ar(32'h8000_0200, 1'b1, 8'd1, 2'b01, 3'd3);
      n = 0;
      do begin @(negedge clk); n++; end while (s_bus.rvalid !== 1'b1 && n < 50);
      chk("stall_first_rvalid", s_bus.rvalid, 1'b1);
      repeat (5) begin
         @(negedge clk);
         chk("stall_s_rvalid", s_bus.rvalid, 1'b1);
         chk("stall_s_rdata", s_bus.rdata, defpat(32'h8000_0200));
         chk("stall_no_m_arvalid", m_bus.arvalid, 1'b0);
      end
      @(posedge clk); #1;
      s_bus.rready = 1'b1;
      wait_drain("stall_drain");

      // Reset during beat 2 of an 8-beat read with a write in flight
      r_base = r_popped;
      for (int i = 0; i < 8; i++)
         exp_rd(32'h8000_1000 + 32'(i * 8), 1'b1, defpat(32'h8000_1000 + 32'(i * 8)), i == 7);
      w_q.push_back('{addr: 32'h8000_2000, data: 64'hAA, strb: 8'hFF});
      fork
         do_ar(32'h8000_1000, 1'b1, 8'd7, 2'b01, 3'd3);
         begin
            do_aw(32'h8000_2000, 1'b0, 8'd3, 2'b01, 3'd3);
            do_w(64'hAA, 8'hFF, 1'b0);
         end
      join
      n = 0;
      while (r_popped < r_base + 2 && n < 100) begin @(negedge clk); n++; end
      chk("abort_beats_before_reset", r_popped >= r_base + 2, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      ar_q.delete(); r_q.delete(); w_q.delete(); b_q.delete();
      rst = 1'b0;
      @(negedge clk);
      check_idle("abort");
      repeat (10) @(negedge clk);
      @(posedge clk); #1;

      // Fresh concurrent read and write after the abort
      exp_rd(32'h8000_3000, 1'b0, defpat(32'h8000_3000), 1'b0);
      exp_rd(32'h8000_3008, 1'b0, defpat(32'h8000_3008), 1'b1);
      w_q.push_back('{addr: 32'h8000_3100, data: 64'h55, strb: 8'hFF});
      b_q.push_back('{resp: RESP_OKAY, id: 1'b1});
      fork
         do_ar(32'h8000_3000, 1'b0, 8'd1, 2'b01, 3'd3);
         begin
            do_aw(32'h8000_3100, 1'b1, 8'd0, 2'b01, 3'd3);
            do_w(64'h55, 8'hFF, 1'b1);
         end
      join
      wait_drain("post_abort_drain");
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_burst_split.md
# axi_burst_split

Testbench-side AXI4 burst splitter sitting directly upstream of the single-beat AXI memory model (`axi_slv`). It accepts full AXI4 read/write bursts (FIXED/INCR/WRAP, up to 256 beats) from the core/interconnect. It re-issues each burst as a sequence of single-beat transactions (`len=0`) that the memory model can serve. It reassembles read beats with correct `rlast` and collapses write beats into one B response, so multi-beat masters can run against the memory model unchanged.

## Interface
- `TAGW`, 1: AXI ID width.
- `aclk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `s_arvalid`/`s_arready`  in/out  1  upstream AR handshake.
- `s_araddr` in 32, `s_arid` in TAGW, `s_arlen` in 8, `s_arburst` in 2, `s_arsize` in 3: upstream AR payload.
- `s_rvalid`/`s_rready`  out/in  1  upstream R handshake.
- `s_rdata` out 64, `s_rresp` out 2, `s_rid` out TAGW, `s_rlast` out 1: upstream R payload.
- `s_awvalid`/`s_awready`  in/out  1, with `s_awaddr`/`s_awid`/`s_awlen`/`s_awburst`/`s_awsize`: same widths as AR.
- `s_wvalid`/`s_wready`  in/out  1, `s_wdata` in 64, `s_wstrb` in 8, `s_wlast` in 1.
- `s_bvalid`/`s_bready`  out/in  1, `s_bresp` out 2, `s_bid` out TAGW.
- `m_ar*`, `m_r*`, `m_aw*`, `m_w*`, `m_b*`: downstream mirror of the above, with these constraints:
  - `m_arlen`/`m_awlen` are always 0.
  - `m_arburst`/`m_awburst` are always INCR (2'b01).
  - `m_rready`/`m_bready` are tied 1.

## Operation
- Read and write paths are independent FSMs and may run concurrently.
- **Read FSM:** R_IDLE → R_ADDR → R_WAIT → R_RESP → (R_ADDR | R_IDLE).
  - R_IDLE: `s_arready=1`. On handshake, latch addr/id/len/burst/size, set beat counter=0, go to R_ADDR.
  - R_ADDR: `m_arvalid=1` with the current address. On `m_arready`, go to R_WAIT.
  - R_WAIT: on `m_rvalid`, capture rdata/rresp into a holding register, go to R_RESP.
  - R_RESP: `s_rvalid=1`, `s_rlast=(count==len)`. On `s_rready`:
    - if last, go to R_IDLE;
    - otherwise advance address and count, go to R_ADDR.
- **Write FSM:** W_IDLE → W_DATA → W_ISSUE → W_WAITB → (W_DATA | W_RESP) → W_IDLE.
  - W_IDLE: `s_awready=1`; latch AW fields.
  - W_DATA: `s_wready=1`; on handshake, latch data/strb.
  - W_ISSUE: `m_awvalid=m_wvalid=1` in the same cycle, because the memory model writes on `awvalid` together with wdata. Leave on `m_awready&m_wready`.
  - W_WAITB: on `m_bvalid`, accumulate bresp as the maximum across beats. Go to W_RESP if count==len, else advance and go to W_DATA.
  - W_RESP: `s_bvalid=1`, `s_bid=`latched id, until `s_bready`.
- **Wlast check:** `s_wlast` asserted with count≠len, or deasserted with count==len, sets a sticky error. The final `s_bresp` becomes 2'b10 (SLVERR). The beat count, not `wlast`, terminates the burst.
- **Address generation:**
  - step = 1<<size.
  - FIXED: address unchanged.
  - INCR: addr+step, 32-bit wrap-around with no 4 KB check.
  - WRAP: region = (len+1)<<size, aligned down; next = base | ((addr+step) & (region-1)).
  - WRAP with len∉{1,3,7,15} is treated as INCR.
- `rresp` passes through per beat; `rid` is the latched arid.
- **Reset mid-burst:** both FSMs return to IDLE and latched state is discarded. No R/B response is produced for the aborted burst.

## Timing
- Reset values:
  - all `*valid` outputs 0;
  - `s_arready`=`s_awready`=1 (IDLE);
  - `s_wready` 0;
  - data, id, resp and last outputs 0.
- **Read latency:** AR accepted at cycle 0 → `m_arvalid` at cycle 1 → memory model `rvalid` at cycle 2 → `s_rvalid` at cycle 3.
  - Steady-state rate is one beat per 3 cycles with `s_rready` held high.
- **Write:** W beat accepted at cycle n → `m_awvalid/m_wvalid` at n+1 → `m_bvalid` at n+2. Next `s_wready` is asserted at n+3. `s_bvalid` follows the last `m_bvalid` by 1 cycle.
- Only one downstream beat is outstanding per direction. Upstream backpressure holds data stable and blocks the next downstream issue.
- Payload outputs are stable while valid is high and the handshake is incomplete.

## Structure
- Package `axi_split_pkg` holds:
  - burst encodings FIXED/INCR/WRAP;
  - resp codes OKAY/SLVERR;
  - read/write FSM state enums;
  - the legal-WRAP-length constant set.
- Sub-module `axi_addr_gen` (combinational next-address from addr/size/len/burst) is instantiated once per direction.

## Test plan
- INCR read, araddr 0x8000_0010, len 3, size 3 → downstream addrs 0x10, 0x18, 0x20, 0x28 (+0x8000_0000). Four R beats; `rlast` only on the 4th; all carry arid.
- WRAP read, addr 0x8000_0008, len 3, size 2 → downstream 0x08, 0x0C, 0x00, 0x04 (+base).
- FIXED write, addr 0x8000_0100, len 2, wstrb 0xFF, data 1/2/3 → three downstream writes to 0x100. Exactly one B response with OKAY; memory reads back 3.
- Write len 2 with `s_wlast` on beat 1 → three beats still issued; `s_bresp`=2'b10.
- Read len 1 with `s_rready` low for 5 cycles on beat 0 → `s_rdata` held; no second `m_arvalid` until the handshake completes.
- `rst` pulsed during beat 2 of an 8-beat read and concurrent write → all valids 0 next cycle. No `s_rvalid`/`s_bvalid` for the aborted bursts; a new burst completes normally.
